// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: four-digit multiplexed seven-segment driver with frame-synchronous display updates
module seg7_scan_driver #(
  parameter int SCAN_DIV = 100000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [15:0] disp_data,
  input  logic        disp_load,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  bcd7,
  output logic        frame_done
);
  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  logic [CW-1:0] cnt;
  logic [1:0]    idx, nidx;
  logic [15:0]   shadow, disp, ndisp;
  logic          tick, boundary, lz;
  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction
  assign tick     = cnt == CW'(SCAN_DIV - 1);
  assign boundary = tick && idx == 2'd3;
  assign nidx     = idx + 2'd1;
  // The digit shown right after a boundary must already see the freshly committed frame
  assign ndisp    = boundary ? shadow : disp;
  assign lz       = LZ_BLANK && nidx != 2'd0 && (ndisp >> {nidx, 2'b00}) == 16'd0;
  // Scan timing: prescaler and digit index
  always_ff @(posedge sysclk) begin
    if (reset) begin
      cnt <= '0;
      idx <= 2'd0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      idx <= tick ? nidx : idx;
    end
  end
  // Shadow capture and frame-boundary commit into the display register
  always_ff @(posedge sysclk) begin
    if (reset) begin
      shadow     <= '0;
      disp       <= '0;
      frame_done <= 1'b0;
    end else begin
      if (disp_load) shadow <= disp_data;
      disp       <= ndisp;
      frame_done <= boundary;
    end
  end
  // Registered digit outputs: blank overrides, otherwise refresh only when the index advances
  always_ff @(posedge sysclk) begin
    if (reset || blank) begin
      an   <= 4'hF;
      bcd7 <= 7'h7F;
    end else if (tick) begin
      an   <= lz ? 4'hF : ~(4'b0001 << nidx);
      bcd7 <= lz ? 7'h7F : decode(ndisp[{nidx, 2'b00} +: 4]);
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: table, directed and randomized checks of seg7_scan_driver against a frame-level model
module tb_seg7_scan_driver;
  localparam int SD = 4;
  logic sysclk = 1'b0, reset = 1'b1, disp_load = 1'b0, blank = 1'b0;
  logic [15:0] disp_data = '0;
  logic [3:0] an1, an0;
  logic [6:0] seg1, seg0;
  logic fd1, fd0;
  int passed = 0, total = 0;
  int n = 0;
  logic [15:0] sh = '0, dsp = '0;
  logic [3:0] m_an [2];
  logic [6:0] m_seg [2];
  logic m_fd = 1'b0;
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef struct packed {
    logic [15:0]      data;
    logic [3:0][6:0]  s1;
    logic [3:0][6:0]  s0;
  } vec_t;
  vec_t tab [5];
  int fdq [$];

  seg7_scan_driver #(.SCAN_DIV(SD), .LZ_BLANK(1'b1)) dut1 (
    .sysclk(sysclk), .reset(reset), .disp_data(disp_data), .disp_load(disp_load),
    .blank(blank), .an(an1), .bcd7(seg1), .frame_done(fd1));
  seg7_scan_driver #(.SCAN_DIV(SD), .LZ_BLANK(1'b0)) dut0 (
    .sysclk(sysclk), .reset(reset), .disp_data(disp_data), .disp_load(disp_load),
    .blank(blank), .an(an0), .bcd7(seg0), .frame_done(fd0));

  always #5 sysclk = ~sysclk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic off();
    for (int z = 0; z < 2; z++) begin
      m_an[z]  = 4'hF;
      m_seg[z] = 7'h7F;
    end
  endtask

  // digit d of the display value; instance 1 blanks a digit whose value and all higher ones are zero
  task automatic show(input int d);
    for (int z = 0; z < 2; z++) begin
      if (z == 1 && d != 0 && int'(dsp) < (1 << (4 * d))) begin
        m_an[z]  = 4'hF;
        m_seg[z] = 7'h7F;
      end else begin
        m_an[z]  = 4'hF ^ (4'b0001 << d);
        m_seg[z] = seg_tab[(int'(dsp) >> (4 * d)) % 16];
      end
    end
  endtask

  // one clock: advance the model from the inputs seen at this edge, then compare both instances
  task automatic cyc();
    bit tk, bnd;
    int d;
    @(posedge sysclk);
    if (reset) begin
      n = 0; sh = '0; dsp = '0; m_fd = 1'b0;
      off();
    end else begin
      tk  = (n % SD) == SD - 1;
      d   = ((n + 1) / SD) % 4;
      bnd = tk && d == 0;
      m_fd = bnd;
      if (bnd) dsp = sh;
      if (disp_load) sh = disp_data;
      if (blank) off();
      else if (tk) show(d);
      n++;
    end
    #1;
    chk("an_lz1", an1, m_an[1]);
    chk("seg_lz1", seg1, m_seg[1]);
    chk("fd_lz1", fd1, m_fd);
    chk("an_lz0", an0, m_an[0]);
    chk("seg_lz0", seg0, m_seg[0]);
    chk("fd_lz0", fd0, m_fd);
  endtask

  task automatic wait_fd();
    int k;
    k = 0;
    do begin cyc(); k++; end while (!fd1 && k < 40);
    chk("fd_wait", fd1, 1'b1);
  endtask

  initial begin
    tab[0] = '{16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}};
    tab[1] = '{16'h00A0, {7'h7F, 7'h7F, 7'h08, 7'h40}, {7'h40, 7'h40, 7'h08, 7'h40}};
    tab[2] = '{16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}};
    tab[3] = '{16'h0708, {7'h7F, 7'h78, 7'h40, 7'h00}, {7'h40, 7'h78, 7'h40, 7'h00}};
    tab[4] = '{16'hC0DE, {7'h46, 7'h40, 7'h21, 7'h06}, {7'h46, 7'h40, 7'h21, 7'h06}};
    // reset with a load that must be ignored
    disp_load = 1'b1; disp_data = 16'hFFFF;
    repeat (3) cyc();
    reset = 1'b0; disp_load = 1'b0;
    // idle after reset: frame_done first 16 edges after release, then every 16
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (fd1) fdq.push_back(i);
    end
    chk("fd_count", 16'(fdq.size()), 16'd2);
    if (fdq.size() == 2) begin
      chk("fd_first", 16'(fdq[0]), 16'd16);
      chk("fd_period", 16'(fdq[1] - fdq[0]), 16'd16);
    end
    wait_fd();
    cyc();
    // table: load mid-frame, then inspect each slot of the following frame
    for (int i = 0; i < 5; i++) begin
      disp_load = 1'b1; disp_data = tab[i].data;
      cyc();
      disp_load = 1'b0;
      wait_fd();
      for (int k = 0; k < 4; k++) begin
        if (k > 0) repeat (SD) cyc();
        chk($sformatf("tab%0d_d%0d_seg_lz1", i, k), seg1, tab[i].s1[k]);
        chk($sformatf("tab%0d_d%0d_an_lz1", i, k), an1,
            tab[i].s1[k] == 7'h7F ? 4'hF : 4'hF ^ (4'b0001 << k));
        chk($sformatf("tab%0d_d%0d_seg_lz0", i, k), seg0, tab[i].s0[k]);
      end
    end
    // load on the boundary tick: skipped by the next frame, shown in the one after
    wait_fd();
    repeat (15) cyc();
    disp_load = 1'b1; disp_data = 16'hBEEF;
    cyc();
    disp_load = 1'b0;
    chk("beef_fd1", fd1, 1'b1);
    chk("beef_not_yet", seg1, 7'h06);
    repeat (16) cyc();
    chk("beef_fd2", fd1, 1'b1);
    chk("beef_d0_seg", seg1, 7'h0E);
    chk("beef_d0_an", an1, 4'hE);
    repeat (12) cyc();
    chk("beef_d3_seg", seg1, 7'h03);
    chk("beef_d3_an", an1, 4'h7);
    // blank for 10 cycles mid-frame
    wait_fd();
    repeat (5) cyc();
    blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("blank_an", an1, 4'hF);
      chk("blank_seg", seg1, 7'h7F);
    end
    blank = 1'b0;
    cyc();
    chk("unblank_fd", fd1, 1'b1);
    chk("unblank_seg", seg1, 7'h0E);
    chk("unblank_an", an1, 4'hE);
    // reset at index 2 aborts the frame and clears the display
    wait_fd();
    repeat (8) cyc();
    reset = 1'b1; disp_load = 1'b1; disp_data = 16'h1111;
    repeat (3) cyc();
    reset = 1'b0; disp_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_hold_an", an1, 4'hF);
      chk("rst_hold_seg", seg1, 7'h7F);
      chk("rst_hold_fd", fd1, 1'b0);
    end
    cyc();
    chk("rst_tick_an_lz1", an1, 4'hF);
    chk("rst_tick_an_lz0", an0, 4'hD);
    chk("rst_tick_seg_lz0", seg0, 7'h40);
    wait_fd();
    chk("rst_disp_seg", seg1, 7'h40);
    chk("rst_disp_an", an1, 4'hE);
    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      disp_load = $urandom_range(0, 5) == 0;
      disp_data = 16'($urandom) >> (4 * $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) blank = !blank;
      reset = $urandom_range(0, 150) == 0;
      cyc();
    end
    reset = 1'b0; blank = 1'b0; disp_load = 1'b0;
    repeat (20) cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
